// File: rtl/mux2_share_arb.sv
// mux2_share_arb: round-robin owner selection for one shared 2:1 inverting
// mux lane. The select only moves on the edge that hands the lane to a new
// owner, and every release is followed by an idle turnaround with both
// grants low. A hold limit stops one requester from starving the other.
module mux2_share_arb #(
  parameter int MAXHOLD = 8,
  parameter int GAP     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQA,
  input  logic       REQB,
  input  logic       LASTA,
  input  logic       LASTB,
  output logic       GNTA,
  output logic       GNTB,
  output logic       SEL,
  output logic       BUSY,
  output logic       PREEMPT,
  output logic [7:0] HOLDCNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT  = 8'(MAXHOLD);
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_t     state;
  logic [3:0] gap_cnt;
  logic       last_b;
  logic       hold_full;

  assign hold_full = (HOLDCNT == MAX_CNT);

  // Arbitration FSM; every output is updated here so all of them are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
      last_b  <= 1'b1;
      GNTA    <= 1'b0;
      GNTB    <= 1'b0;
      SEL     <= 1'b0;
      BUSY    <= 1'b0;
      PREEMPT <= 1'b0;
      HOLDCNT <= 8'd0;
    end else begin
      PREEMPT <= 1'b0;
      case (state)
        IDLE: begin
          if (REQA && (!REQB || last_b)) begin
            state   <= OWN_A;
            GNTA    <= 1'b1;
            SEL     <= 1'b0;
            last_b  <= 1'b0;
            HOLDCNT <= 8'd1;
            BUSY    <= 1'b1;
          end else if (REQB) begin
            state   <= OWN_B;
            GNTB    <= 1'b1;
            SEL     <= 1'b1;
            last_b  <= 1'b1;
            HOLDCNT <= 8'd1;
            BUSY    <= 1'b1;
          end else begin
            BUSY    <= 1'b0;
          end
        end
        OWN_A: begin
          if (LASTA || !REQA || (hold_full && REQB)) begin
            state   <= TURN;
            GNTA    <= 1'b0;
            HOLDCNT <= 8'd0;
            gap_cnt <= GAP_LOAD;
            PREEMPT <= !LASTA && REQA;
          end else if (!hold_full) begin
            HOLDCNT <= HOLDCNT + 8'd1;
          end
        end
        OWN_B: begin
          if (LASTB || !REQB || (hold_full && REQA)) begin
            state   <= TURN;
            GNTB    <= 1'b0;
            HOLDCNT <= 8'd0;
            gap_cnt <= GAP_LOAD;
            PREEMPT <= !LASTB && REQB;
          end else if (!hold_full) begin
            HOLDCNT <= HOLDCNT + 8'd1;
          end
        end
        TURN: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          GNTA  <= 1'b0;
          GNTB  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_share_arb.sv
// tb_mux2_share_arb: directed scenarios for the shared-lane arbiter with a
// hold limit of 4 and a one-cycle turnaround. Expected output vectors are
// worked out by hand, cycle by cycle, for each step.
module tb_mux2_share_arb;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       last_a;
  logic       last_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       sel;
  logic       busy;
  logic       preempt;
  logic [7:0] holdcnt;

  int checks = 0;
  int fails  = 0;

  mux2_share_arb #(.MAXHOLD(4), .GAP(1)) dut (
    .CLK     (clk),
    .RST     (rst),
    .REQA    (req_a),
    .REQB    (req_b),
    .LASTA   (last_a),
    .LASTB   (last_b),
    .GNTA    (gnt_a),
    .GNTB    (gnt_b),
    .SEL     (sel),
    .BUSY    (busy),
    .PREEMPT (preempt),
    .HOLDCNT (holdcnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Grants must never overlap, checked mid-cycle whenever reset is released.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(gnt_a && gnt_b)) else begin
        fails++;
        $error("[TB] FAIL grant_overlap observed=%b%b expected=not both high", gnt_a, gnt_b);
      end
    end
  end

  // Packs expected {GNTA,GNTB,SEL,BUSY,PREEMPT,HOLDCNT} into one vector.
  function automatic logic [12:0] pack(input logic ga, input logic gb, input logic s,
                                       input logic b, input logic p, input logic [7:0] h);
    return {ga, gb, s, b, p, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ra, input logic rb, input logic la, input logic lb);
    req_a  = ra;
    req_b  = rb;
    last_a = la;
    last_b = lb;
  endtask

  task automatic check_output(input string tag, input logic [12:0] expected);
    logic [12:0] observed;
    observed = {gnt_a, gnt_b, sel, busy, preempt, holdcnt};
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b (ga gb sel busy pre hold)", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    #12;
    check_output("reset_values", pack(0, 0, 0, 0, 0, 8'd0));
    rst = 1'b0;

    // A alone: grant after one edge, LASTA on third granted cycle.
    $display("[TB] single requester A with LASTA");
    apply_stimulus(1, 0, 0, 0);
    tick(); check_output("a_only_c1", pack(1, 0, 0, 1, 0, 8'd1));
    tick(); check_output("a_only_c2", pack(1, 0, 0, 1, 0, 8'd2));
    tick(); check_output("a_only_c3", pack(1, 0, 0, 1, 0, 8'd3));
    apply_stimulus(1, 0, 1, 0);
    tick(); check_output("a_only_turn", pack(0, 0, 0, 1, 0, 8'd0));
    apply_stimulus(0, 0, 0, 0);
    tick(); check_output("a_only_idle", pack(0, 0, 0, 0, 0, 8'd0));
    tick(); check_output("a_only_idle2", pack(0, 0, 0, 0, 0, 8'd0));

    // Tie after reset: A first, B gets the lane GAP+1 cycles after GNTA falls.
    $display("[TB] tie after reset");
    rst = 1'b1; #2; rst = 1'b0;
    apply_stimulus(1, 1, 0, 0);
    tick(); check_output("tie_a_first", pack(1, 0, 0, 1, 0, 8'd1));
    apply_stimulus(1, 1, 1, 0);
    tick(); check_output("tie_turn", pack(0, 0, 0, 1, 0, 8'd0));
    apply_stimulus(0, 1, 0, 0);
    tick(); check_output("tie_idle", pack(0, 0, 0, 0, 0, 8'd0));
    tick(); check_output("tie_b_grant", pack(0, 1, 1, 1, 0, 8'd1));
    apply_stimulus(0, 1, 0, 1);
    tick(); check_output("tie_b_turn_sel_held", pack(0, 0, 1, 1, 0, 8'd0));
    apply_stimulus(0, 0, 0, 0);
    tick(); check_output("tie_b_idle", pack(0, 0, 1, 0, 0, 8'd0));

    // Preempt: A holds with no LASTA, B requests on grant cycle 2.
    $display("[TB] hold limit preempt");
    apply_stimulus(1, 0, 0, 0);
    tick(); check_output("pre_c1", pack(1, 0, 0, 1, 0, 8'd1));
    tick(); check_output("pre_c2", pack(1, 0, 0, 1, 0, 8'd2));
    apply_stimulus(1, 1, 0, 0);
    tick(); check_output("pre_c3", pack(1, 0, 0, 1, 0, 8'd3));
    tick(); check_output("pre_c4", pack(1, 0, 0, 1, 0, 8'd4));
    tick(); check_output("pre_pulse", pack(0, 0, 0, 1, 1, 8'd0));
    tick(); check_output("pre_idle", pack(0, 0, 0, 0, 0, 8'd0));
    tick(); check_output("pre_b_grant", pack(0, 1, 1, 1, 0, 8'd1));
    apply_stimulus(0, 0, 0, 0);
    tick(); check_output("pre_b_abort", pack(0, 0, 1, 1, 0, 8'd0));
    tick(); check_output("pre_b_idle", pack(0, 0, 1, 0, 0, 8'd0));

    // Saturation: A alone for 20 cycles keeps the lane, HOLDCNT stops at 4.
    $display("[TB] hold count saturation");
    apply_stimulus(1, 0, 0, 0);
    tick(); check_output("sat_c1", pack(1, 0, 0, 1, 0, 8'd1));
    for (int k = 2; k <= 20; k++) begin
      tick();
      check_output("sat_cycle", pack(1, 0, 0, 1, 0, (k < 4) ? 8'(k) : 8'd4));
    end
    apply_stimulus(0, 0, 0, 0);
    tick(); check_output("sat_release", pack(0, 0, 0, 1, 0, 8'd0));
    tick(); check_output("sat_idle", pack(0, 0, 0, 0, 0, 8'd0));

    // Abort: REQA dropped with B waiting, then gap, then B.
    $display("[TB] abort and LASTA at hold limit");
    apply_stimulus(1, 0, 0, 0);
    tick(); check_output("abort_a_c1", pack(1, 0, 0, 1, 0, 8'd1));
    apply_stimulus(1, 1, 0, 0);
    tick(); check_output("abort_a_c2", pack(1, 0, 0, 1, 0, 8'd2));
    apply_stimulus(0, 1, 0, 0);
    tick(); check_output("abort_turn", pack(0, 0, 0, 1, 0, 8'd0));
    tick(); check_output("abort_idle", pack(0, 0, 0, 0, 0, 8'd0));
    apply_stimulus(1, 1, 0, 0);
    tick(); check_output("abort_b_grant", pack(0, 1, 1, 1, 0, 8'd1));
    apply_stimulus(1, 1, 0, 1);
    tick(); check_output("b_last_turn", pack(0, 0, 1, 1, 0, 8'd0));
    apply_stimulus(1, 0, 0, 0);
    tick(); check_output("b_last_idle", pack(0, 0, 1, 0, 0, 8'd0));
    tick(); check_output("lim_a_c1", pack(1, 0, 0, 1, 0, 8'd1));
    apply_stimulus(1, 1, 0, 0);
    tick(); check_output("lim_a_c2", pack(1, 0, 0, 1, 0, 8'd2));
    tick(); check_output("lim_a_c3", pack(1, 0, 0, 1, 0, 8'd3));
    tick(); check_output("lim_a_c4", pack(1, 0, 0, 1, 0, 8'd4));
    apply_stimulus(1, 1, 1, 0);
    tick(); check_output("lim_last_no_preempt", pack(0, 0, 0, 1, 0, 8'd0));
    apply_stimulus(0, 0, 0, 0);
    tick(); check_output("lim_idle", pack(0, 0, 0, 0, 0, 8'd0));

    // Asynchronous reset in the middle of a B ownership.
    $display("[TB] asynchronous reset during B ownership");
    apply_stimulus(0, 1, 0, 0);
    tick(); check_output("rst_b_c1", pack(0, 1, 1, 1, 0, 8'd1));
    tick(); check_output("rst_b_c2", pack(0, 1, 1, 1, 0, 8'd2));
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_immediate", pack(0, 0, 0, 0, 0, 8'd0));
    apply_stimulus(1, 1, 0, 0);
    #2;
    rst = 1'b0;
    tick(); check_output("rst_then_a_first", pack(1, 0, 0, 1, 0, 8'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mux2_share_arb.md
Name: mux2_share_arb

Overview:
- Round-robin arbiter that shares one 2:1 inverting mux lane between two requesters, A and B.
- Sequences the mux select (SEL drives the mux S pin) so it only changes while neither grant is asserted.
- Enforces a turnaround gap between owners and a maximum hold time, so one requester cannot starve the other.
- Sits between requester handshake logic and the MUX2X1-based shared output lane.

Parameters:
- MAXHOLD, 8: maximum consecutive granted cycles before forced release when the other side is waiting. Legal range 1..255.
- GAP, 1: number of idle turnaround cycles, with both grants low, after every release. Legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- REQA  input  1  requester A wants the lane; held high for the whole transaction
- REQB  input  1  requester B wants the lane
- LASTA  input  1  A's final beat; meaningful only while GNTA=1
- LASTB  input  1  B's final beat; meaningful only while GNTB=1
- GNTA  output  1  A owns the lane (registered)
- GNTB  output  1  B owns the lane (registered)
- SEL  output  1  mux select: 0 selects A, 1 selects B (registered)
- BUSY  output  1  high in OWN_A, OWN_B or TURN states
- PREEMPT  output  1  one-cycle pulse when the owner is forcibly released by MAXHOLD
- HOLDCNT  output  8  cycles granted to the current owner, saturating at MAXHOLD

Behaviour:
- Clocking and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values:
  - state IDLE
  - GNTA=0, GNTB=0, SEL=0, BUSY=0, PREEMPT=0, HOLDCNT=0
  - last-winner pointer LW=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B, TURN.
- All outputs are registered; every decision is made on the sampled inputs at a rising edge.
- IDLE:
  - REQA&REQB: grant the side that is not LW.
  - Only one request high: grant that side.
  - No request: stay in IDLE.
  - On a grant, at the same edge: state goes to OWN_x, GNTx=1, SEL=(x==B), LW=x, HOLDCNT=1.
  - Latency: a request seen in IDLE at edge n gives GNT high after edge n.
- OWN_x, release conditions (any one ends ownership at that edge; the next state is TURN):
  - LASTx=1 sampled while GNTx=1: normal end, and that cycle counts as a transferred beat.
  - REQx=0 sampled: abort.
  - HOLDCNT==MAXHOLD and the other request is high: preempt, PREEMPT=1 for exactly the next cycle.
- OWN_x, no release: HOLDCNT increments, saturating at MAXHOLD.
  - If the other side is not requesting, the owner keeps the lane indefinitely.
- Release priority: when LASTx and a preempt coincide, treat it as a normal end, so PREEMPT stays 0.
- TURN:
  - GNTA=GNTB=0 and HOLDCNT=0.
  - SEL holds its last value.
  - An internal gap counter runs GAP cycles, then returns to IDLE.
  - Requests arriving during TURN are not granted until IDLE evaluates them.
  - Minimum spacing between one grant falling and the next grant rising is GAP+1 cycles.
- Invariants:
  - GNTA and GNTB are never both high.
  - SEL never changes while either grant is high.
  - SEL changes only on the edge that enters OWN_x.
- Mid-operation reset: asynchronous return to the reset values, with grants dropping immediately. In-flight transactions are lost, and requesters must re-request.
- Requester protocol: REQx deasserted while GNTx=0 is legal (the request is withdrawn). LASTx while not granted is ignored.

Test Plan:
- REQA=1 from reset (GAP=1): GNTA=1 and SEL=0 one cycle later. Assert LASTA on the 3rd granted cycle: GNTA=0 next cycle, BUSY through 1 TURN cycle, IDLE after.
- REQA=REQB=1 together after reset: A is granted first (LW=B). After LASTA, B is granted GAP+1 cycles after GNTA falls, with SEL rising on the same edge as GNTB.
- MAXHOLD=4, A holds REQA with no LASTA, B requests at grant cycle 2: GNTA high for exactly 4 cycles, PREEMPT pulse, TURN, then GNTB with SEL=1.
- MAXHOLD=4, only A requesting for 20 cycles: GNTA stays high and HOLDCNT saturates at 4 with no PREEMPT.
- A granted, REQA dropped mid-burst with B waiting: GNTA falls next cycle, followed by the gap and then GNTB. Also, LASTA coinciding with HOLDCNT==MAXHOLD gives PREEMPT=0.
- RST pulsed asynchronously mid-OWN_B (between clock edges): GNTB=0 and SEL=0 immediately. After release with both requesting, A is granted first.
